id_ex_stage: RTL

//  ID/EX pipeline register for the 5-stage MIPS-style core, with load-use hazard detection.

---
 rtl/id_ex_stage_pkg.sv | 22 ++
 rtl/id_ex_stage_if.sv | 40 ++++
 rtl/id_ex_stage_load_use_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 113 +++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: register-field widths, the $0 register
// and the ALU operation encodings.
package id_ex_stage_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned CTRL_W     = 5;  // RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc
  localparam int unsigned ALUOP_BITS = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [ALUOP_BITS-1:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluSlt = 4'd5,
    AluLui = 4'd6,
    AluNor = 4'd7
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX pipeline register.
// The master drives decode; the slave is the stage itself.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 16
);
    logic [4:0]         rs_IF_ID, rt_IF_ID, rd_IF_ID;
    logic               use_rs_IF_ID, use_rt_IF_ID, RegDst_ID;
    logic               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID;
    logic [ALUOP_W-1:0] ALUOp_ID;
    logic [DATA_W-1:0]  rdata1_ID, rdata2_ID, imm_ID, pc_ID;
    logic               flush;

    logic [4:0]         rs_ID_EX, rt_ID_EX, rd_ID_EX;
    logic               RegWrite_ID_EX, MemRead_ID_EX, MemWrite_ID_EX, MemtoReg_ID_EX;
    logic               ALUSrc_ID_EX;
    logic [ALUOP_W-1:0] ALUOp_ID_EX;
    logic [DATA_W-1:0]  rdata1_ID_EX, rdata2_ID_EX, imm_ID_EX, pc_ID_EX;
    logic               valid_ID_EX, PCWrite, IF_ID_Write;
    logic [CNT_W-1:0]   stall_count;

    modport master (
        output rs_IF_ID, rt_IF_ID, rd_IF_ID, use_rs_IF_ID, use_rt_IF_ID, RegDst_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, ALUOp_ID,
               rdata1_ID, rdata2_ID, imm_ID, pc_ID, flush,
        input  rs_ID_EX, rt_ID_EX, rd_ID_EX, RegWrite_ID_EX, MemRead_ID_EX, MemWrite_ID_EX,
               MemtoReg_ID_EX, ALUSrc_ID_EX, ALUOp_ID_EX, rdata1_ID_EX, rdata2_ID_EX,
               imm_ID_EX, pc_ID_EX, valid_ID_EX, PCWrite, IF_ID_Write, stall_count
    );

    modport slave (
        input  rs_IF_ID, rt_IF_ID, rd_IF_ID, use_rs_IF_ID, use_rt_IF_ID, RegDst_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, ALUOp_ID,
               rdata1_ID, rdata2_ID, imm_ID, pc_ID, flush,
        output rs_ID_EX, rt_ID_EX, rd_ID_EX, RegWrite_ID_EX, MemRead_ID_EX, MemWrite_ID_EX,
               MemtoReg_ID_EX, ALUSrc_ID_EX, ALUOp_ID_EX, rdata1_ID_EX, rdata2_ID_EX,
               imm_ID_EX, pc_ID_EX, valid_ID_EX, PCWrite, IF_ID_Write, stall_count
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard: a valid load in EX whose destination is read by
// the instruction in decode. Loads into $0 never stall.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic             memread_ex_i,
    input  logic             valid_ex_i,
    input  logic [REG_W-1:0] rt_ex_i,
    input  logic [REG_W-1:0] rs_id_i,
    input  logic [REG_W-1:0] rt_id_i,
    input  logic             use_rs_id_i,
    input  logic             use_rt_id_i,
    output logic             hazard_o
);
    logic rs_match, rt_match;

    always_comb begin
        rs_match = use_rs_id_i && (rt_ex_i == rs_id_i);
        rt_match = use_rt_id_i && (rt_ex_i == rt_id_i);
        hazard_o = memread_ex_i && valid_ex_i && (rt_ex_i != REG_ZERO) && (rs_match || rt_match);
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion, plus a
// saturating counter of stall cycles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    logic [REG_W-1:0]   rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic [CTRL_W-1:0]  ctrl_d, ctrl_q;
    logic [ALUOP_W-1:0] aluop_d, aluop_q;
    logic [DATA_W-1:0]  rdata1_d, rdata1_q, rdata2_d, rdata2_q;
    logic [DATA_W-1:0]  imm_d, imm_q, pc_d, pc_q;
    logic               valid_d, valid_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               hazard;

    load_use_detect u_load_use_detect (
        .memread_ex_i (ctrl_q[3]),
        .valid_ex_i   (valid_q),
        .rt_ex_i      (rt_q),
        .rs_id_i      (bus.rs_IF_ID),
        .rt_id_i      (bus.rt_IF_ID),
        .use_rs_id_i  (bus.use_rs_IF_ID),
        .use_rt_id_i  (bus.use_rt_IF_ID),
        .hazard_o     (hazard)
    );

    // Default is a bubble; only a normal cycle captures the decode instruction.
    always_comb begin
        rs_d     = '0;
        rt_d     = '0;
        rd_d     = '0;
        ctrl_d   = '0;
        aluop_d  = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        pc_d     = '0;
        valid_d  = 1'b0;
        cnt_d    = cnt_q;
        if (bus.flush) begin
            cnt_d = cnt_q;
        end else if (hazard) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else begin
            rs_d     = bus.rs_IF_ID;
            rt_d     = bus.rt_IF_ID;
            rd_d     = bus.RegDst_ID ? bus.rd_IF_ID : bus.rt_IF_ID;
            ctrl_d   = {bus.RegWrite_ID, bus.MemRead_ID, bus.MemWrite_ID, bus.MemtoReg_ID,
                        bus.ALUSrc_ID};
            aluop_d  = bus.ALUOp_ID;
            rdata1_d = bus.rdata1_ID;
            rdata2_d = bus.rdata2_ID;
            imm_d    = bus.imm_ID;
            pc_d     = bus.pc_ID;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            aluop_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            aluop_q  <= aluop_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    // A flush overrides the stall so the redirect can proceed.
    assign bus.PCWrite     = bus.flush || !hazard;
    assign bus.IF_ID_Write = bus.flush || !hazard;

    assign bus.rs_ID_EX       = rs_q;
    assign bus.rt_ID_EX       = rt_q;
    assign bus.rd_ID_EX       = rd_q;
    assign bus.RegWrite_ID_EX = ctrl_q[4];
    assign bus.MemRead_ID_EX  = ctrl_q[3];
    assign bus.MemWrite_ID_EX = ctrl_q[2];
    assign bus.MemtoReg_ID_EX = ctrl_q[1];
    assign bus.ALUSrc_ID_EX   = ctrl_q[0];
    assign bus.ALUOp_ID_EX    = aluop_q;
    assign bus.rdata1_ID_EX   = rdata1_q;
    assign bus.rdata2_ID_EX   = rdata2_q;
    assign bus.imm_ID_EX      = imm_q;
    assign bus.pc_ID_EX       = pc_q;
    assign bus.valid_ID_EX    = valid_q;
    assign bus.stall_count    = cnt_q;
endmodule
